bus_transfer_controller: RTL and testbench
==========================================

# bus_transfer_controller

Initiator side of the shared 16-bit register bus. It accepts one move request at a time (source register to destination register) and sequences the per-register output-enable and input-enable strobes. It guarantees at most one bus driver per cycle and a dead turnaround cycle between transfers. It sits between the instruction decode/control logic and the register file, and drives the `*_out_en` / `*_input_en` pins of every register.

## Interface
- `NUM_REGS`, default 8: number of registers on the bus (power of two, 2..16).
- `DATA_W`, default 16: bus width.
- `bus_clock` in 1: single clock, rising edge.
- `bus_reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: move request present.
- `req_ready` out 1: controller can accept a request this cycle.
- `req_src` in log2(NUM_REGS): source register index.
- `req_dst` in log2(NUM_REGS): destination register index.
- `req_imm` in 1: load `req_data` instead of reading a register (only with `BUS_XFER_IMM_EN`).
- `req_data` in DATA_W: immediate value.
- `reg_out_en` out NUM_REGS: one-hot (or zero) register output enables.
- `reg_in_en` out NUM_REGS: one-hot (or zero) register input enables.
- `bus_data` inout DATA_W: shared bus; driven by the controller only for immediates.
- `xfer_done` out 1: one-cycle pulse when a transfer completes.
- `xfer_err` out 1: one-cycle pulse, coincident with `xfer_done`, for a rejected (src==dst) request.
- `last_value` out DATA_W: bus value captured in the LATCH cycle.

## Operation
- FSM states are IDLE, DRIVE, LATCH, DONE.
- **IDLE:** `req_ready`=1, all enables 0. On `req_valid` & `req_ready`, register src, dst, imm and data.
  - src!=dst or imm: go to DRIVE.
  - src==dst and not imm: go straight to DONE with `xfer_err`=1 and no enables.
- **DRIVE:** `reg_out_en[src]`=1 (or the immediate driver enabled). `reg_in_en`=0. This is the bus settle cycle.
- **LATCH:** source enable held, `reg_in_en[dst]`=1. `last_value` <= `bus_data` at the end of this cycle.
- **DONE:** all enables 0, `xfer_done`=1, `req_ready`=0. This is the turnaround cycle. Next state is IDLE.
- Invariants:
  - popcount(`reg_out_en`) + immediate-driver-enable <= 1 at all times.
  - popcount(`reg_in_en`) <= 1 at all times.
  - `reg_in_en` is never asserted without a driver.
- Requests are ignored outside IDLE. `req_valid` need not be held after acceptance.
- Indices are always in range (NUM_REGS is a power of two), so no wrap handling is needed.

## Timing
- Request accepted on edge T (IDLE, valid&ready). DRIVE covers T..T+1, LATCH covers T+1..T+2, DONE covers T+2..T+3, and IDLE resumes at T+3.
- Destination register captures on the edge that ends LATCH.
- Back-to-back throughput is one transfer per 4 cycles. The error path takes 2 cycles (IDLE, DONE).
- Reset values: state IDLE, `req_ready`=1 after reset release, enables 0, `xfer_done`=0, `xfer_err`=0, `last_value`=0, `bus_data` high-Z.
- Reset asserted mid-transfer clears all enables and releases the bus immediately (asynchronously). No partial write completes.
- `req_ready` is a registered state decode, with no combinational path from `req_valid`.

## Configuration
- `BUS_XFER_IMM_EN` defined:
  - `req_imm`=1 enables an internal tristate that drives `req_data` onto `bus_data` during DRIVE and LATCH; `req_src` is ignored.
  - src==dst checking does not apply to immediates.
- Not defined:
  - `req_imm` and `req_data` are ignored and every request is a register move.
  - `bus_data` is input-only in effect (never driven).
  - The immediate driver logic is absent.

## Structure
- Package `bus_xfer_pkg` holds:
  - the state enum (IDLE, DRIVE, LATCH, DONE);
  - `BUS_DATA_W`=16;
  - default `BUS_NUM_REGS`=8;
  - index width as `$clog2(BUS_NUM_REGS)`.
- One sub-module, `bus_onehot_decode`: index plus enable in, one-hot NUM_REGS vector out. It is instantiated twice (out and in enables).
- The immediate driver reuses the team's existing tristate buffer cell.

## Test plan
- Reset, then move src=2 to dst=5 with reg2=16'hA5A5. Expect `reg_out_en`=8'h04 for 2 cycles and `reg_in_en`=8'h20 in LATCH only. Reg5=16'hA5A5, `last_value`=16'hA5A5, `xfer_done` pulse at T+2..T+3.
- Move src=3 to dst=3. Expect no enables ever, `xfer_done`=1 and `xfer_err`=1 one cycle after acceptance, `req_ready` back after 2 cycles.
- `req_valid` held high with 3 queued moves (0→1, 1→2, 2→7). Expect exactly 3 accepts 4 cycles apart, and no cycle with two out_en bits set.
- Assert `bus_reset_n`=0 during LATCH of 4→6. Expect enables 0 before the next edge, reg6 unchanged, state IDLE, and `req_ready`=1 after release.
- With `BUS_XFER_IMM_EN`: imm request, data=16'h1234, dst=0. Expect `reg_out_en`=0 throughout, bus=16'h1234 in DRIVE/LATCH, reg0=16'h1234, and bus high-Z in DONE.
- Without `BUS_XFER_IMM_EN`: same request with src=1 (reg1=16'h00FF). Expect reg0=16'h00FF, and `req_data` has no effect.

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the register-bus transfer controller: FSM state
// encoding, default bus geometry and the derived register index width.
package bus_xfer_pkg;

  localparam int BUS_DATA_W   = 16;
  localparam int BUS_NUM_REGS = 8;
  localparam int BUS_IDX_W    = $clog2(BUS_NUM_REGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/bus_onehot_decode.sv
// Index-to-one-hot decoder for register enable strobes. With en low the
// output is all zeros, so a disabled decoder can never select a register.
module bus_onehot_decode
  import bus_xfer_pkg::*;
#(
  parameter int NUM_REGS = BUS_NUM_REGS
) (
  input  logic [$clog2(NUM_REGS)-1:0] idx,
  input  logic                        en,
  output logic [NUM_REGS-1:0]         onehot
);

  // Single bit set at idx when enabled, otherwise no strobe.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_tristate_buf.sv
// Team tristate buffer cell: drives a onto y while en is high, otherwise
// releases y to high-Z. Only built when BUS_XFER_IMM_EN is defined, since
// the immediate driver is its only user on this bus.
`ifdef BUS_XFER_IMM_EN
module bus_tristate_buf #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] a,
  inout  wire  [W-1:0] y
);

  assign y = en ? a : {W{1'bz}};

endmodule
`endif

// File: rtl/bus_transfer_controller.sv
// Initiator for the shared register bus. Accepts one move at a time and
// sequences IDLE -> DRIVE -> LATCH -> DONE so that at most one register (or
// the immediate driver) drives the bus, the destination captures at the end
// of LATCH, and DONE leaves a dead turnaround cycle before the next move.
// Optional feature macro: BUS_XFER_IMM_EN adds immediate loads from req_data.
module bus_transfer_controller
  import bus_xfer_pkg::*;
#(
  parameter int NUM_REGS = BUS_NUM_REGS,
  parameter int DATA_W   = BUS_DATA_W
) (
  input  logic                        bus_clock,
  input  logic                        bus_reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_REGS)-1:0] req_src,
  input  logic [$clog2(NUM_REGS)-1:0] req_dst,
  input  logic                        req_imm,
  input  logic [DATA_W-1:0]           req_data,
  output logic [NUM_REGS-1:0]         reg_out_en,
  output logic [NUM_REGS-1:0]         reg_in_en,
  inout  wire  [DATA_W-1:0]           bus_data,
  output logic                        xfer_done,
  output logic                        xfer_err,
  output logic [DATA_W-1:0]           last_value
);

  localparam int IDX_W = $clog2(NUM_REGS);

  xfer_state_t      state;
  xfer_state_t      next_state;
  logic [IDX_W-1:0] src_q;
  logic [IDX_W-1:0] dst_q;
  logic             err_q;
  logic             accept;
  logic             req_is_err;
  logic             src_phase;
  logic             out_active;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign src_phase = (state == DRIVE) || (state == LATCH);
  assign xfer_done = (state == DONE);
  assign xfer_err  = (state == DONE) & err_q;

`ifdef BUS_XFER_IMM_EN
  logic              imm_q;
  logic [DATA_W-1:0] data_q;
  logic              imm_drv;

  // Immediates have no source register, so a src==dst clash is meaningless.
  assign req_is_err = ~req_imm & (req_src == req_dst);
  assign out_active = src_phase & ~imm_q;
  assign imm_drv    = src_phase & imm_q;

  // Capture the immediate payload with the move; datapath, no reset needed.
  always_ff @(posedge bus_clock) begin
    if (accept) begin
      imm_q  <= req_imm;
      data_q <= req_data;
    end
  end

  bus_tristate_buf #(
    .W (DATA_W)
  ) u_imm_drv (
    .en (imm_drv),
    .a  (data_q),
    .y  (bus_data)
  );
`else
  // Immediate inputs have no function in this build; the bus is never driven.
  logic unused_imm;
  assign unused_imm = ^{req_imm, req_data};

  assign req_is_err = (req_src == req_dst);
  assign out_active = src_phase;
`endif

  // State register; reset drops every enable and releases the bus at once.
  always_ff @(posedge bus_clock or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: rejected moves skip straight to the turnaround cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = req_is_err ? DONE : DRIVE;
      DRIVE:   next_state = LATCH;
      LATCH:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Error flag for the accepted move, reported alongside xfer_done.
  always_ff @(posedge bus_clock or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_is_err;
    end
  end

  // Register indices of the accepted move; only read while enables are live.
  always_ff @(posedge bus_clock) begin
    if (accept) begin
      src_q <= req_src;
      dst_q <= req_dst;
    end
  end

  // Snapshot of the bus on the same edge the destination register captures.
  always_ff @(posedge bus_clock or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      last_value <= '0;
    end else if (state == LATCH) begin
      last_value <= bus_data;
    end
  end

  bus_onehot_decode #(
    .NUM_REGS (NUM_REGS)
  ) u_out_dec (
    .idx    (src_q),
    .en     (out_active),
    .onehot (reg_out_en)
  );

  bus_onehot_decode #(
    .NUM_REGS (NUM_REGS)
  ) u_in_dec (
    .idx    (dst_q),
    .en     (state == LATCH),
    .onehot (reg_in_en)
  );

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Bench for bus_transfer_controller with an 8-entry register-file model
// attached to the bus. Optional feature macro: BUS_XFER_IMM_EN.
module tb_bus_transfer_controller;

  logic        bus_clock = 1'b0;
  logic        bus_reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_src;
  logic [2:0]  req_dst;
  logic        req_imm;
  logic [15:0] req_data;
  logic [7:0]  reg_out_en;
  logic [7:0]  reg_in_en;
  wire  [15:0] bus_data;
  logic        xfer_done;
  logic        xfer_err;
  logic [15:0] last_value;

  int n_pass  = 0;
  int n_total = 0;
  int inv_viol = 0;

  logic [15:0] regs [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [15:0] pre_val = 16'h0;

  bus_transfer_controller #(
    .NUM_REGS (8),
    .DATA_W   (16)
  ) dut (
    .bus_clock   (bus_clock),
    .bus_reset_n (bus_reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src     (req_src),
    .req_dst     (req_dst),
    .req_imm     (req_imm),
    .req_data    (req_data),
    .reg_out_en  (reg_out_en),
    .reg_in_en   (reg_in_en),
    .bus_data    (bus_data),
    .xfer_done   (xfer_done),
    .xfer_err    (xfer_err),
    .last_value  (last_value)
  );

  always #5 bus_clock = ~bus_clock;

  function automatic logic [2:0] enc(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) return i[2:0];
    end
    return 3'd0;
  endfunction

  // Register file model: selected register drives the bus, enabled one captures.
  assign bus_data = (reg_out_en != 8'h00) ? regs[enc(reg_out_en)] : 16'hzzzz;

  always @(posedge bus_clock) begin
    if (pre_we) regs[pre_idx] <= pre_val;
    for (int i = 0; i < 8; i++) begin
      if (reg_in_en[i]) regs[i] <= bus_data;
    end
  end

  // Bus invariants watched on every cycle outside reset.
  always @(negedge bus_clock) begin
    if (bus_reset_n) begin
      if ($countones(reg_out_en) > 1) inv_viol++;
      if ($countones(reg_in_en) > 1) inv_viol++;
`ifndef BUS_XFER_IMM_EN
      if (reg_in_en != 8'h00 && reg_out_en == 8'h00) inv_viol++;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic preload(input logic [2:0] idx, input logic [15:0] val);
    @(negedge bus_clock);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(posedge bus_clock);
    #1 pre_we = 1'b0;
  endtask

  // Presents one request from a negedge, holds it across the accept edge,
  // and returns at the negedge of the first post-accept cycle.
  task automatic issue(input logic [2:0] src, input logic [2:0] dst,
                       input logic imm, input logic [15:0] data);
    @(negedge bus_clock);
    check("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_src   = src;
    req_dst   = dst;
    req_imm   = imm;
    req_data  = data;
    @(posedge bus_clock);
    #1 req_valid = 1'b0;
    req_imm = 1'b0;
    @(negedge bus_clock);
  endtask

  typedef struct {
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] val;
    logic [7:0]  exp_out;
    logic [7:0]  exp_in;
    logic        exp_err;
  } vec_t;

  vec_t vecs [4];

  int          acc_cyc [3];
  int          k;
  logic        will_acc;
  logic [2:0]  q_src [3];
  logic [2:0]  q_dst [3];

  initial begin
    vecs[0] = '{src: 3'd2, dst: 3'd5, val: 16'hA5A5, exp_out: 8'h04, exp_in: 8'h20, exp_err: 1'b0};
    vecs[1] = '{src: 3'd3, dst: 3'd3, val: 16'h3333, exp_out: 8'h00, exp_in: 8'h00, exp_err: 1'b1};
    vecs[2] = '{src: 3'd7, dst: 3'd0, val: 16'h7E57, exp_out: 8'h80, exp_in: 8'h01, exp_err: 1'b0};
    vecs[3] = '{src: 3'd0, dst: 3'd6, val: 16'h0F0F, exp_out: 8'h01, exp_in: 8'h40, exp_err: 1'b0};
    q_src[0] = 3'd0; q_dst[0] = 3'd1;
    q_src[1] = 3'd1; q_dst[1] = 3'd2;
    q_src[2] = 3'd2; q_dst[2] = 3'd7;

    bus_reset_n = 1'b0;
    req_valid   = 1'b0;
    req_src     = 3'd0;
    req_dst     = 3'd0;
    req_imm     = 1'b0;
    req_data    = 16'h0;
    repeat (2) @(negedge bus_clock);
    bus_reset_n = 1'b1;
    @(negedge bus_clock);
    check("rst_ready",      {31'd0, req_ready}, 32'd1);
    check("rst_out_en",     {24'd0, reg_out_en}, 32'h0);
    check("rst_in_en",      {24'd0, reg_in_en}, 32'h0);
    check("rst_done",       {31'd0, xfer_done}, 32'd0);
    check("rst_err",        {31'd0, xfer_err}, 32'd0);
    check("rst_last_value", {16'd0, last_value}, 32'h0);

    // Table-driven single moves; req_data carries junk that must be ignored.
    for (int v = 0; v < 4; v++) begin
      preload(vecs[v].src, vecs[v].val);
      if (vecs[v].dst != vecs[v].src) preload(vecs[v].dst, 16'hDEAD);
      issue(vecs[v].src, vecs[v].dst, 1'b0, ~vecs[v].val);
      if (!vecs[v].exp_err) begin
        check("drive_out_en", {24'd0, reg_out_en}, {24'd0, vecs[v].exp_out});
        check("drive_in_en",  {24'd0, reg_in_en}, 32'h0);
        check("drive_done",   {31'd0, xfer_done}, 32'd0);
        @(negedge bus_clock);
        check("latch_out_en", {24'd0, reg_out_en}, {24'd0, vecs[v].exp_out});
        check("latch_in_en",  {24'd0, reg_in_en}, {24'd0, vecs[v].exp_in});
        @(negedge bus_clock);
      end
      check("done_out_en",  {24'd0, reg_out_en}, 32'h0);
      check("done_in_en",   {24'd0, reg_in_en}, 32'h0);
      check("done_pulse",   {31'd0, xfer_done}, 32'd1);
      check("done_err",     {31'd0, xfer_err}, {31'd0, vecs[v].exp_err});
      check("done_ready",   {31'd0, req_ready}, 32'd0);
      check("dst_value",    {16'd0, regs[vecs[v].dst]}, {16'd0, vecs[v].val});
      if (!vecs[v].exp_err) check("last_value", {16'd0, last_value}, {16'd0, vecs[v].val});
      @(negedge bus_clock);
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("idle_done",  {31'd0, xfer_done}, 32'd0);
    end

    // Back-to-back queue with req_valid held high.
    preload(3'd0, 16'hC0DE);
    @(negedge bus_clock);
    req_valid = 1'b1;
    req_src   = q_src[0];
    req_dst   = q_dst[0];
    k = 0;
    for (int c = 0; c < 30 && k < 3; c++) begin
      will_acc = req_ready;
      if (will_acc) acc_cyc[k] = c;
      @(posedge bus_clock);
      #1;
      if (will_acc) begin
        k++;
        if (k < 3) begin
          req_src = q_src[k];
          req_dst = q_dst[k];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge bus_clock);
    end
    req_valid = 1'b0;
    check("b2b_accepts", k, 3);
    if (k == 3) begin
      check("b2b_gap0", acc_cyc[1] - acc_cyc[0], 4);
      check("b2b_gap1", acc_cyc[2] - acc_cyc[1], 4);
    end
    repeat (3) @(negedge bus_clock);
    check("b2b_reg1", {16'd0, regs[1]}, 32'hC0DE);
    check("b2b_reg2", {16'd0, regs[2]}, 32'hC0DE);
    check("b2b_reg7", {16'd0, regs[7]}, 32'hC0DE);

    // Reset asserted during LATCH of 4 -> 6.
    preload(3'd4, 16'h4444);
    preload(3'd6, 16'h6666);
    issue(3'd4, 3'd6, 1'b0, 16'h0);
    check("rstx_drive_out", {24'd0, reg_out_en}, 32'h10);
    @(negedge bus_clock);
    check("rstx_latch_in", {24'd0, reg_in_en}, 32'h40);
    #1 bus_reset_n = 1'b0;
    #1;
    check("rstx_out_cleared", {24'd0, reg_out_en}, 32'h0);
    check("rstx_in_cleared",  {24'd0, reg_in_en}, 32'h0);
    @(negedge bus_clock);
    bus_reset_n = 1'b1;
    #1;
    check("rstx_ready",      {31'd0, req_ready}, 32'd1);
    check("rstx_last_value", {16'd0, last_value}, 32'h0);
    @(negedge bus_clock);
    check("rstx_reg6_kept", {16'd0, regs[6]}, 32'h6666);
    check("rstx_idle_ready", {31'd0, req_ready}, 32'd1);

`ifdef BUS_XFER_IMM_EN
    // Immediate load: no register drives, controller puts req_data on the bus.
    preload(3'd0, 16'h0000);
    issue(3'd3, 3'd0, 1'b1, 16'h1234);
    check("imm_drive_out", {24'd0, reg_out_en}, 32'h0);
    check("imm_drive_bus", {16'd0, bus_data}, 32'h1234);
    @(negedge bus_clock);
    check("imm_latch_out", {24'd0, reg_out_en}, 32'h0);
    check("imm_latch_in",  {24'd0, reg_in_en}, 32'h01);
    check("imm_latch_bus", {16'd0, bus_data}, 32'h1234);
    @(negedge bus_clock);
    check("imm_done",  {31'd0, xfer_done}, 32'd1);
    check("imm_reg0",  {16'd0, regs[0]}, 32'h1234);
    check("imm_last",  {16'd0, last_value}, 32'h1234);
`else
    // Immediate flag without the feature: plain move from src, req_data ignored.
    preload(3'd1, 16'h00FF);
    preload(3'd0, 16'h0000);
    issue(3'd1, 3'd0, 1'b1, 16'h1234);
    check("noimm_drive_out", {24'd0, reg_out_en}, 32'h02);
    @(negedge bus_clock);
    check("noimm_latch_in", {24'd0, reg_in_en}, 32'h01);
    @(negedge bus_clock);
    check("noimm_done", {31'd0, xfer_done}, 32'd1);
    check("noimm_reg0", {16'd0, regs[0]}, 32'h00FF);
    check("noimm_last", {16'd0, last_value}, 32'h00FF);
`endif
    @(negedge bus_clock);
    check("invariants", inv_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
